// File: rtl/brick_scan_if.sv
// brick_scan_if
// Groups the two buses that brick_scan sits between: the brick memory read
// port and the shared VGA draw unit.
//   mem_address  brick memory read address (driven by the scanner)
//   mem_health   brick memory read data, one cycle after the address
//   x_out/y_out  top-left pixel of the brick being drawn
//   colour       fill colour for the brick being drawn
//   draw_req     high while a draw is wanted and x/y/colour are valid
//   draw_done    draw unit has finished the current brick
// master: the scanner side. slave: the memory + draw unit side.
interface brick_scan_if;
  logic [9:0] mem_address;
  logic [1:0] mem_health;
  logic [9:0] x_out;
  logic [9:0] y_out;
  logic [2:0] colour;
  logic       draw_req;
  logic       draw_done;

  modport master (
    output mem_address, x_out, y_out, colour, draw_req,
    input  mem_health, draw_done
  );

  modport slave (
    input  mem_address, x_out, y_out, colour, draw_req,
    output mem_health, draw_done
  );
endinterface

// File: rtl/brick_scan.sv
// brick_scan
// Walks the brick memory one address per brick, turns each address into a
// screen position, asks the draw unit to repaint the brick in a colour taken
// from its health, and counts how many bricks are still alive. A one-cycle
// done pulse marks the end of a pass; bricks_left then holds the live count.
// Ports:
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset
//   start        request a pass (only looked at while idle)
//   bus          memory read port + draw unit handshake (master side)
//   busy         high whenever a pass is in progress, including DONE
//   done         one-cycle pulse at the end of a pass
//   bricks_left  live brick count from the last completed pass
module brick_scan #(
  parameter int BRICK_NUM = 40,
  parameter int COLS      = 16,
  parameter int BRICK_W   = 10,
  parameter int BRICK_H   = 5,
  parameter int Y_OFF     = 10
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  brick_scan_if.master       bus,
  output logic               busy,
  output logic               done,
  output logic [9:0]         bricks_left
);

  localparam int         COL_BITS  = $clog2(COLS);
  localparam logic [9:0] COL_MASK  = 10'(COLS - 1);
  localparam logic [9:0] LAST_ADDR = 10'(BRICK_NUM - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    DRAW,
    NEXT,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] addr_q, addr_d;
  logic [9:0] live_q, live_d;
  logic [9:0] left_q, left_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [1:0] health_q, health_d;
  logic [2:0] colour_q, colour_d;
  logic       draw_req_q, draw_req_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [9:0] col;
  logic [9:0] row;

  // Health 0 paints black so that destroyed bricks get erased from screen.
  function automatic logic [2:0] health_colour(input logic [1:0] health);
    case (health)
      2'd1:    health_colour = 3'b010;
      2'd2:    health_colour = 3'b110;
      2'd3:    health_colour = 3'b100;
      default: health_colour = 3'b000;
    endcase
  endfunction

  // COLS is a power of two, so the column is the low address bits and the
  // row is what remains above them. Position math wraps at 10 bits.
  always_comb begin
    col = addr_q & COL_MASK;
    row = addr_q >> COL_BITS;
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    live_d   = live_q;
    left_d   = left_q;
    x_d      = x_q;
    y_d      = y_q;
    health_d = health_q;
    colour_d = colour_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = '0;
          live_d  = '0;
          state_d = READ;
        end
      end
      READ: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Synchronous RAM: the data for addr_q is on mem_health now.
        health_d = bus.mem_health;
        colour_d = health_colour(bus.mem_health);
        x_d      = col * 10'(BRICK_W);
        y_d      = 10'(Y_OFF) + row * 10'(BRICK_H);
        state_d  = DRAW;
      end
      DRAW: begin
        if (bus.draw_done) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (health_q != 2'd0) begin
          live_d = live_q + 10'd1;
        end
        if (addr_q == LAST_ADDR) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + 10'd1;
          state_d = READ;
        end
      end
      DONE: begin
        left_d  = live_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake/status outputs are registered, so they are decoded from the
    // state being entered rather than the current one.
    draw_req_d = (state_d == DRAW);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      live_q     <= '0;
      left_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      health_q   <= '0;
      colour_q   <= '0;
      draw_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      live_q     <= live_d;
      left_q     <= left_d;
      x_q        <= x_d;
      y_q        <= y_d;
      health_q   <= health_d;
      colour_q   <= colour_d;
      draw_req_q <= draw_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.mem_address = addr_q;
  assign bus.x_out       = x_q;
  assign bus.y_out       = y_q;
  assign bus.colour      = colour_q;
  assign bus.draw_req    = draw_req_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign bricks_left     = left_q;

endmodule

// File: tb/tb_brick_scan.sv
// tb_brick_scan
// Drives a 40-brick scanner (dut_a) against a synchronous RAM model and a
// draw unit model that is either instant or stalls, plus a 1-brick scanner
// (dut_b). Expected draws and done pulses are queued per pass and compared
// as the scanner produces them.
module tb_brick_scan;

  typedef struct {
    int addr;
    int x;
    int y;
    int col;
    int cyc;
  } draw_t;

  typedef struct {
    int cyc;
    int left;
  } done_t;

  logic       clk;
  logic       resetn;
  logic       start_a;
  logic       start_b;
  logic       busy_a, done_a, busy_b, done_b;
  logic [9:0] bricks_left_a, bricks_left_b;
  logic       stall_mode;
  logic [3:0] req_cnt;
  logic [1:0] mem_a [0:1023];
  logic [1:0] mem_b [0:1023];

  int checks = 0;
  int errors = 0;

  draw_t draw_q[$];
  done_t done_q[$];
  draw_t rec;
  done_t drec;
  int    pass_cyc = 0;
  int    draw_cycles_a = 0;
  int    done_count = 0;
  int    exp_left = 0;
  bit    prev_req = 0;
  bit    check_left_next = 0;
  logic [9:0] hold_x, hold_y, hold_addr;
  logic [2:0] hold_col;

  brick_scan_if a_if ();
  brick_scan_if b_if ();

  brick_scan #(.BRICK_NUM(40)) dut_a (
    .clk(clk), .resetn(resetn), .start(start_a), .bus(a_if),
    .busy(busy_a), .done(done_a), .bricks_left(bricks_left_a)
  );

  brick_scan #(.BRICK_NUM(1)) dut_b (
    .clk(clk), .resetn(resetn), .start(start_b), .bus(b_if),
    .busy(busy_b), .done(done_b), .bricks_left(bricks_left_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous brick memories.
  always @(posedge clk) begin
    a_if.mem_health <= mem_a[a_if.mem_address];
    b_if.mem_health <= mem_b[b_if.mem_address];
  end

  // Draw unit model: instant, or finishing in the 7th cycle of each request.
  always @(posedge clk) begin
    if (!a_if.draw_req) req_cnt <= 4'd0;
    else                req_cnt <= req_cnt + 4'd1;
  end
  assign a_if.draw_done = stall_mode ? (a_if.draw_req && (req_cnt == 4'd6)) : 1'b1;
  assign b_if.draw_done = 1'b1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Queue the expected draws and done pulse for one pass of dut_a, given
  // the number of cycles each brick takes.
  task automatic pushPass(input int period);
    draw_t r;
    done_t d;
    int live;
    live = 0;
    for (int i = 0; i < 40; i++) begin
      r.addr = i;
      r.x    = (i % 16) * 10;
      r.y    = 10 + (i / 16) * 5;
      case (mem_a[i])
        2'd1:    r.col = 2;
        2'd2:    r.col = 6;
        2'd3:    r.col = 4;
        default: r.col = 0;
      endcase
      r.cyc = period * i + 3;
      if (mem_a[i] != 2'd0) live++;
      draw_q.push_back(r);
    end
    d.cyc  = period * 40 + 1;
    d.left = live;
    done_q.push_back(d);
  endtask

  // Pulse start on dut_a, optionally pulse it again mid-pass, and wait
  // (bounded) for the done pulse.
  task automatic applyStimulus(input int budget, input int poke);
    bit seen;
    seen = 0;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (done_a) seen = 1;
      if (poke != 0 && c == poke)     begin #1 start_a = 1'b1; end
      if (poke != 0 && c == poke + 1) begin #1 start_a = 1'b0; end
    end
    checkOutput("done_seen", 32'(seen), 1);
    repeat (3) @(negedge clk);
  endtask

  // Monitor for dut_a, sampling on the falling edge.
  always @(negedge clk) begin
    if (!resetn) begin
      draw_q.delete();
      done_q.delete();
      exp_left = 0;
      prev_req = 0;
      check_left_next = 0;
      pass_cyc = 0;
    end else begin
      if (start_a && !busy_a) begin
        pass_cyc = 0;
        draw_cycles_a = 0;
      end else begin
        pass_cyc++;
      end
      if (a_if.draw_req) begin
        draw_cycles_a++;
        if (!prev_req) begin
          if (draw_q.size() == 0) begin
            checkOutput("unexpected_draw", 1, 0);
          end else begin
            rec = draw_q.pop_front();
            checkOutput("draw_cycle", pass_cyc, rec.cyc);
            checkOutput("draw_addr", 32'(a_if.mem_address), rec.addr);
            checkOutput("draw_x", 32'(a_if.x_out), rec.x);
            checkOutput("draw_y", 32'(a_if.y_out), rec.y);
            checkOutput("draw_colour", 32'(a_if.colour), rec.col);
          end
          hold_x    = a_if.x_out;
          hold_y    = a_if.y_out;
          hold_col  = a_if.colour;
          hold_addr = a_if.mem_address;
        end else begin
          checkOutput("stable_x", 32'(a_if.x_out), 32'(hold_x));
          checkOutput("stable_y", 32'(a_if.y_out), 32'(hold_y));
          checkOutput("stable_colour", 32'(a_if.colour), 32'(hold_col));
          checkOutput("stable_addr", 32'(a_if.mem_address), 32'(hold_addr));
        end
      end
      if (check_left_next) begin
        checkOutput("left_after_done", 32'(bricks_left_a), exp_left);
        check_left_next = 0;
      end
      if (busy_a && !done_a) begin
        checkOutput("left_hold", 32'(bricks_left_a), exp_left);
      end
      if (done_a) begin
        done_count++;
        if (done_q.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          drec = done_q.pop_front();
          checkOutput("done_cycle", pass_cyc, drec.cyc);
          exp_left = drec.left;
          check_left_next = 1;
        end
      end
      prev_req = a_if.draw_req;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    int b_draws;
    int b_dones;
    bit b_prev;
    resetn     = 1'b0;
    start_a    = 1'b0;
    start_b    = 1'b0;
    stall_mode = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 2'd0;
      mem_b[i] = 2'd0;
    end
    mem_a[1]  = 2'd3;
    mem_a[2]  = 2'd1;
    mem_a[3]  = 2'd3;
    mem_a[4]  = 2'd3;
    mem_a[5]  = 2'd2;
    mem_a[33] = 2'd1;

    #1;
    checkOutput("rst_mem_address", 32'(a_if.mem_address), 0);
    checkOutput("rst_x", 32'(a_if.x_out), 0);
    checkOutput("rst_y", 32'(a_if.y_out), 0);
    checkOutput("rst_colour", 32'(a_if.colour), 0);
    checkOutput("rst_draw_req", 32'(a_if.draw_req), 0);
    checkOutput("rst_busy", 32'(busy_a), 0);
    checkOutput("rst_done", 32'(done_a), 0);
    checkOutput("rst_left", 32'(bricks_left_a), 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    $display("[TB] full pass, instant draw unit");
    pushPass(4);
    applyStimulus(200, 0);
    checkOutput("fast_draw_cycles", draw_cycles_a, 40);
    checkOutput("fast_left", 32'(bricks_left_a), 6);

    $display("[TB] second pass after clearing address 1");
    mem_a[1] = 2'd0;
    pushPass(4);
    applyStimulus(200, 0);
    checkOutput("second_left", 32'(bricks_left_a), 5);

    $display("[TB] start pulsed during a pass");
    d0 = done_count;
    pushPass(4);
    applyStimulus(200, 20);
    checkOutput("single_done", done_count, d0 + 1);
    repeat (10) @(negedge clk);
    checkOutput("idle_after_poke", 32'(busy_a), 0);
    checkOutput("no_extra_done", done_count, d0 + 1);

    $display("[TB] stalling draw unit");
    stall_mode = 1'b1;
    pushPass(10);
    applyStimulus(450, 0);
    checkOutput("stall_draw_cycles", draw_cycles_a, 280);
    stall_mode = 1'b0;

    $display("[TB] reset during DRAW");
    pushPass(4);
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (int c = 0; c < 20 && !a_if.draw_req; c++) @(negedge clk);
    checkOutput("req_seen", 32'(a_if.draw_req), 1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("mid_rst_mem_address", 32'(a_if.mem_address), 0);
    checkOutput("mid_rst_x", 32'(a_if.x_out), 0);
    checkOutput("mid_rst_y", 32'(a_if.y_out), 0);
    checkOutput("mid_rst_colour", 32'(a_if.colour), 0);
    checkOutput("mid_rst_draw_req", 32'(a_if.draw_req), 0);
    checkOutput("mid_rst_busy", 32'(busy_a), 0);
    checkOutput("mid_rst_done", 32'(done_a), 0);
    checkOutput("mid_rst_left", 32'(bricks_left_a), 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    pushPass(4);
    applyStimulus(200, 0);
    checkOutput("post_rst_left", 32'(bricks_left_a), 5);

    $display("[TB] single brick scanner");
    b_draws = 0;
    b_dones = 0;
    b_prev  = 0;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (b_if.draw_req && !b_prev) begin
        b_draws++;
        checkOutput("b_draw_cycle", c, 3);
        checkOutput("b_x", 32'(b_if.x_out), 0);
        checkOutput("b_y", 32'(b_if.y_out), 10);
        checkOutput("b_colour", 32'(b_if.colour), 0);
      end
      if (done_b) begin
        b_dones++;
        checkOutput("b_done_cycle", c, 5);
      end
      b_prev = b_if.draw_req;
    end
    checkOutput("b_draws", b_draws, 1);
    checkOutput("b_dones", b_dones, 1);
    checkOutput("b_left", 32'(bricks_left_b), 0);
    checkOutput("b_idle", 32'(busy_b), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/brick_scan.md
# brick_scan

Reads brick state back out of the brick memory that the level loader fills, one brick per step. For each brick it converts the address to a screen position, requests a redraw in a colour derived from health, and counts the bricks still alive. It sits between the brick memory read port and the shared VGA draw unit, and is triggered by the game controller after collisions or at frame refresh. Its `done` pulse tells the controller whether the level is cleared (`bricks_left == 0`).

## Interface
Parameters:
- `BRICK_NUM`, 40: bricks per pass, at addresses 0..BRICK_NUM-1. Legal range 1..1023.
- `COLS`, 16: bricks per row. Must be a power of two.
- `BRICK_W`, 10: brick width in pixels.
- `BRICK_H`, 5: brick height in pixels.
- `Y_OFF`, 10: y pixel of row 0.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: request a scan pass. Sampled only in IDLE.
- `mem_address` out 10: brick memory read address.
- `mem_health` in 2: brick memory read data, valid one cycle after `mem_address` changes (synchronous RAM).
- `x_out` out 10: brick top-left x pixel, for the draw unit.
- `y_out` out 10: brick top-left y pixel, for the draw unit.
- `colour` out 3: fill colour for the draw unit.
- `draw_req` out 1: held high while `x_out`/`y_out`/`colour` are valid and a draw is wanted.
- `draw_done` in 1: draw unit has finished the current brick.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a pass.
- `bricks_left` out 10: count of bricks with nonzero health from the last completed pass.

## Operation
States: IDLE, READ, WAIT, DRAW, NEXT, DONE.
- IDLE: `start`=1 → clear the address counter and the live counter → READ. Otherwise stay in IDLE.
- READ: `mem_address` = current address → WAIT. Unconditional.
- WAIT: `mem_health` is valid in this cycle. Latch it into the health register at the cycle end. Latch `x_out`/`y_out` from the address → DRAW.
- DRAW: `draw_req`=1. Leave for NEXT in the cycle `draw_done`=1 is sampled; otherwise stay. `x_out`, `y_out`, `colour` stay constant throughout DRAW.
- NEXT: if latched health ≠ 0, increment the live counter. Then:
  - address == BRICK_NUM-1 → DONE.
  - otherwise increment the address → READ.
- DONE: `done`=1. Copy the live counter into `bricks_left` at the cycle end → IDLE.

Address mapping:
- col = address[log2(COLS)-1:0], row = address >> log2(COLS).
- `x_out` = col*BRICK_W; `y_out` = Y_OFF + row*BRICK_H.
- Both computed in 10-bit arithmetic and truncated; there is no overflow check.

Colour from health:
- 0 → 3'b000 (erase)
- 1 → 3'b010
- 2 → 3'b110
- 3 → 3'b100

Dead bricks (health 0) are still drawn, in black, so destroyed bricks get erased.

Other rules:
- `start` outside IDLE is ignored. It is not queued.
- `draw_done` outside DRAW is ignored.
- `bricks_left` changes only at the end of DONE. It holds its value across passes and while a pass is in progress.

## Timing
- Reset (async assert, any state): state=IDLE. All outputs 0: `mem_address`, `x_out`, `y_out`, `colour`, `draw_req`, `busy`, `done`, `bricks_left`. Internal counters and the health register are cleared.
- Reset mid-pass aborts the pass. No `done` pulse is produced, and `bricks_left` returns to 0.
- Release of reset is taken on a clock edge. The first possible READ is one cycle after `start` is sampled.
- Per brick: READ(1) + WAIT(1) + DRAW(≥1) + NEXT(1). The minimum is 4 cycles, when `draw_done` is high in the first DRAW cycle.
- With `draw_done` tied high and `start` sampled at edge 0:
  - brick i occupies cycles 4i+1 .. 4i+4;
  - DONE (`done`=1) is in cycle 4·BRICK_NUM+1;
  - the block is back in IDLE at cycle 4·BRICK_NUM+2.
- `start` held high continuously: a new pass begins one cycle after DONE (IDLE lasts 1 cycle).
- Outputs are registered. `draw_req` goes high in the first DRAW cycle and low in the NEXT cycle.
- `busy` is high from the READ cycle through the DONE cycle inclusive.

## Test plan
- Reset mid-DRAW:
  - Stimulus: assert `resetn`=0 asynchronously between clock edges during a DRAW state.
  - Response: all outputs read 0 immediately; the next `start` begins a pass at address 0.
- Full pass, fast draw unit:
  - Setup: BRICK_NUM=40; memory health at addresses 1..5 = 3,1,3,3,2; address 33 = 1; all others 0; `draw_done` tied high.
  - Stimulus: pulse `start`.
  - Response: `done` in cycle 161; `bricks_left`=6 after it; exactly 40 `draw_req` cycles. Address 5 draws at x=50, y=10, `colour`=3'b110. Address 33 draws at x=10, y=20, `colour`=3'b010.
- Draw handshake stall:
  - Stimulus: `draw_done` asserted 7 cycles after each `draw_req` rises.
  - Response: each brick takes 10 cycles. `x_out`/`y_out`/`colour` are stable over every DRAW cycle. `mem_address` does not advance until `draw_done` is seen.
- `start` during a pass:
  - Stimulus: pulse `start` while `busy`=1.
  - Response: the pass is unaffected; only one `done` pulse; the block returns to IDLE.
- Boundary, single brick:
  - Setup: BRICK_NUM=1, address 0 health 0.
  - Response: `done` in cycle 5; `bricks_left`=0; one black draw at x=0, y=10.
- Two passes:
  - Stimulus: run a pass with 6 live bricks, clear address 1 in memory, run a second pass.
  - Response: `bricks_left` reads 6 throughout the second pass, then 5 after its `done`.
